// File: rtl/rule_stream_arbiter.sv
// Packet-atomic round-robin merge of NUM_IN sop/eop streams into one registered stream.
// Latency 1 cycle; in_ready is 0 for all ports whenever the output register is full and stalled.
module rule_stream_arbiter #(
  parameter int NUM_IN  = 4,
  parameter int DATA_W  = 256,
  parameter int EMPTY_W = 5,
  parameter int SRC_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_IN-1:0]          in_valid,
  input  logic [NUM_IN-1:0]          in_sop,
  input  logic [NUM_IN-1:0]          in_eop,
  input  logic [NUM_IN*EMPTY_W-1:0]  in_empty,
  input  logic [NUM_IN*DATA_W-1:0]   in_data,
  output logic [NUM_IN-1:0]          in_ready,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [EMPTY_W-1:0]         out_empty,
  output logic [DATA_W-1:0]          out_data,
  output logic [SRC_W-1:0]           out_src,
  input  logic                       out_ready,
  output logic [15:0]                err_cnt
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_nxt;
  logic [SRC_W-1:0]   ptr, ptr_nxt, gnt, gnt_nxt;
  logic [SRC_W-1:0]   sel, cur;
  logic               any_vld, ld, xfer, fwd, err_inc;
  logic               cur_sop, cur_eop;
  logic [EMPTY_W-1:0] cur_empty;
  logic [DATA_W-1:0]  cur_data;

  // Round-robin search starting one past the last served port; descending loop so the nearest wins.
  always_comb begin
    sel     = '0;
    any_vld = 1'b0;
    for (int k = NUM_IN; k >= 1; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_IN;
      if (in_valid[idx]) begin
        sel     = SRC_W'(idx);
        any_vld = 1'b1;
      end
    end
  end

  assign ld  = !out_valid || out_ready;
  assign cur = (state == BUSY) ? gnt : sel;

  always_comb begin
    in_ready = '0;
    if (rst_n && ld && (state == BUSY || any_vld))
      in_ready[cur] = 1'b1;
  end

  assign xfer      = |(in_valid & in_ready);
  assign cur_sop   = in_sop[cur];
  assign cur_eop   = in_eop[cur];
  assign cur_empty = in_empty[int'(cur)*EMPTY_W +: EMPTY_W];
  assign cur_data  = in_data[int'(cur)*DATA_W +: DATA_W];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    fwd       = 1'b0;
    err_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (cur_sop) begin
            fwd = 1'b1;
            if (cur_eop) begin
              ptr_nxt = sel;
            end else begin
              state_nxt = BUSY;
              gnt_nxt   = sel;
            end
          end else begin
            // Orphan beat: consumed so the port cannot wedge, but never forwarded.
            err_inc = 1'b1;
            ptr_nxt = sel;
          end
        end
      end
      BUSY: begin
        if (xfer) begin
          fwd = 1'b1;
          if (cur_sop) err_inc = 1'b1;
          if (cur_eop) begin
            state_nxt = IDLE;
            ptr_nxt   = gnt;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= SRC_W'(NUM_IN - 1);
      gnt       <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_empty <= '0;
      out_data  <= '0;
      out_src   <= '0;
      err_cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      if (ld) begin
        out_valid <= fwd;
        if (fwd) begin
          out_sop   <= cur_sop;
          out_eop   <= cur_eop;
          out_empty <= cur_empty;
          out_data  <= cur_data;
          out_src   <= cur;
        end
      end
      if (err_inc && err_cnt != 16'hFFFF)
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rule_stream_arbiter.sv
// Directed scoreboard bench for rule_stream_arbiter: per-port packet sources, expected beats
// queued in predicted arbitration order, compared as the merged stream emerges.
module tb_rule_stream_arbiter;
  localparam int N  = 4;
  localparam int DW = 256;
  localparam int EW = 5;
  localparam int SW = 3;

  typedef struct packed {
    logic [SW-1:0] src;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_sop = '0;
  logic [N-1:0]    in_eop = '0;
  logic [N*EW-1:0] in_empty = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_ready;
  logic            out_valid, out_sop, out_eop;
  logic [EW-1:0]   out_empty;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_src;
  logic            out_ready = 1'b1;
  logic [15:0]     err_cnt;

  rule_stream_arbiter #(.NUM_IN(N), .DATA_W(DW), .EMPTY_W(EW), .SRC_W(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_empty(in_empty), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_empty(out_empty), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  beat_t   stim_q [N][$];
  beat_t   exp_q[$];
  int      passes = 0;
  int      total = 0;
  bit      sb_en = 1'b1;
  logic [N-1:0]  acc = '0;
  logic          stalled = 1'b0;
  logic [DW-1:0] prev_data = '0;
  int            run = 0;
  int            last_run = 0;

  task automatic chk(string tag, logic [263:0] obs, logic [263:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [DW-1:0] mkd(int p, int id, int b);
    logic [31:0] w;
    w = {8'(p), 8'(id), 8'(b), 8'hA5};
    return {8{w}};
  endfunction

  task automatic push_beat(int p, bit s, bit e, logic [EW-1:0] em, logic [DW-1:0] d, bit ex);
    beat_t b;
    b.src = SW'(p); b.sop = s; b.eop = e; b.empty = em; b.data = d;
    stim_q[p].push_back(b);
    if (ex) exp_q.push_back(b);
  endtask

  task automatic push_pkt(int p, int id, int nb);
    for (int b = 0; b < nb; b++)
      push_beat(p, b == 0, b == nb - 1, (b == nb - 1) ? EW'(id + 3) : '0, mkd(p, id, b), 1'b1);
  endtask

  function automatic bit stim_busy();
    bit r = 1'b0;
    for (int i = 0; i < N; i++) if (stim_q[i].size() != 0) r = 1'b1;
    return r;
  endfunction

  task automatic drain(string tag);
    int t = 0;
    while ((exp_q.size() != 0 || stim_busy()) && t < 500) begin
      @(posedge clk); #2;
      t++;
    end
    chk(tag, 264'(t < 500), 264'(1));
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Source driver: retire beats accepted at the last edge, then present each port's head beat.
  always @(negedge clk) acc <= in_valid & in_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
      if (stim_q[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_sop[i]   = stim_q[i][0].sop;
        in_eop[i]   = stim_q[i][0].eop;
        in_empty[i*EW +: EW] = stim_q[i][0].empty;
        in_data[i*DW +: DW]  = stim_q[i][0].data;
      end else begin
        in_valid[i] = 1'b0;
      end
    end
  end

  // Output monitor: backpressure rules, scoreboard compare, contiguous-run length.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled <= 1'b0;
      run     <= 0;
    end else begin
      if (out_valid && !out_ready) begin
        chk("bp_in_ready", 264'(in_ready), 264'(0));
        if (stalled) chk("bp_hold_data", 264'(out_data), 264'(prev_data));
        stalled   <= 1'b1;
        prev_data <= out_data;
      end else begin
        stalled <= 1'b0;
      end
      if (out_valid && out_ready) begin
        run <= run + 1;
        if (sb_en) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 264'(out_valid), 264'(0));
          end else begin
            chk("out_src",   264'(out_src),   264'(exp_q[0].src));
            chk("out_sop",   264'(out_sop),   264'(exp_q[0].sop));
            chk("out_eop",   264'(out_eop),   264'(exp_q[0].eop));
            chk("out_empty", 264'(out_empty), 264'(exp_q[0].empty));
            chk("out_data",  264'(out_data),  264'(exp_q[0].data));
            void'(exp_q.pop_front());
          end
        end
      end else begin
        if (run != 0) last_run <= run;
        run <= 0;
      end
    end
  end

  initial begin
    int t;
    #1;
    chk("rst_out_valid", 264'(out_valid), 264'(0));
    chk("rst_err_cnt",   264'(err_cnt),   264'(0));
    chk("rst_in_ready",  264'(in_ready),  264'(0));
    chk("rst_out_data",  264'(out_data),  264'(0));
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single 3-beat packet on port 2.
    push_pkt(2, 1, 3);
    drain("t1_drain");

    // Two rounds from all ports, starting from fresh priority.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) push_pkt(p, 10 + r, 2);
    drain("t2_drain");
    chk("t2_contiguous", 264'(last_run), 264'(16));

    // Port 1 streams packets; port 3 slots in after port 1's first eop.
    do_reset();
    push_pkt(1, 20, 3);
    push_pkt(3, 21, 2);
    push_pkt(1, 22, 2);
    push_pkt(1, 23, 2);
    drain("t3_drain");
    chk("t3_contiguous", 264'(last_run), 264'(9));

    // out_ready toggling 1,0,0,1 during a 4-beat packet.
    push_pkt(2, 30, 4);
    t = 0;
    while ((exp_q.size() != 0 || stim_busy()) && t < 200) begin
      @(posedge clk); #2;
      out_ready = (t % 4 == 0 || t % 4 == 3);
      t++;
    end
    chk("t4_drain", 264'(t < 200), 264'(1));
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // Orphan beat on port 0, then a normal packet on port 0.
    do_reset();
    push_beat(0, 1'b0, 1'b1, 5'd9, mkd(0, 40, 0), 1'b0);
    push_pkt(0, 41, 2);
    drain("t5_drain");
    chk("t5_err_orphan", 264'(err_cnt), 264'(1));

    // Missing eop: second sop inside a packet is forwarded and counted.
    push_beat(1, 1'b1, 1'b0, 5'd0, mkd(1, 50, 0), 1'b1);
    push_beat(1, 1'b1, 1'b1, 5'd4, mkd(1, 50, 1), 1'b1);
    drain("t5b_drain");
    chk("t5b_err_sop", 264'(err_cnt), 264'(2));

    // Reset in the middle of a port 2 packet.
    sb_en = 1'b0;
    push_pkt(2, 60, 6);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    chk("t6_pkt_started", 264'(out_valid), 264'(1));
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", 264'(out_valid), 264'(0));
    chk("t6_out_sop",   264'(out_sop),   264'(0));
    chk("t6_out_eop",   264'(out_eop),   264'(0));
    chk("t6_out_empty", 264'(out_empty), 264'(0));
    chk("t6_out_data",  264'(out_data),  264'(0));
    chk("t6_out_src",   264'(out_src),   264'(0));
    chk("t6_err_cnt",   264'(err_cnt),   264'(0));
    chk("t6_in_ready",  264'(in_ready),  264'(0));
    for (int i = 0; i < N; i++) stim_q[i].delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    sb_en = 1'b1;
    push_pkt(0, 61, 2);
    push_pkt(2, 62, 2);
    drain("t6_drain");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/rule_stream_arbiter.md
# rule_stream_arbiter

Packet-atomic round-robin arbiter that merges NUM_IN independent 256-bit rule-update streams (sop/eop/empty/valid/ready) into the single stream feeding the 256-to-512 rule packer ahead of PCIe. A grant is held from sop to eop, so packets never interleave, and the winning port changes only at packet boundaries. One registered output stage sustains one beat per cycle, including back-to-back packets from different ports.

## Interface
Parameters:
- NUM_IN, 4: number of requesting streams, 2..8.
- DATA_W, 256: beat width.
- EMPTY_W, 5: empty-field width, log2(DATA_W/8).
- SRC_W, 3: width of the source index, at least ceil(log2(NUM_IN)).

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_IN  per-port beat valid.
- in_sop  in  NUM_IN  per-port start of packet.
- in_eop  in  NUM_IN  per-port end of packet.
- in_empty  in  NUM_IN*EMPTY_W  per-port empty bytes; port i occupies slice i.
- in_data  in  NUM_IN*DATA_W  per-port data; port i occupies slice i.
- in_ready  out  NUM_IN  per-port accept.
- out_valid, out_sop, out_eop  out  1 each  merged stream, registered.
- out_empty  out  EMPTY_W  registered.
- out_data  out  DATA_W  registered.
- out_src  out  SRC_W  index of the port that supplied the current out beat.
- out_ready  in  1  downstream (packer) accept.
- err_cnt  out  16  saturating count of protocol errors.

## Operation
- Beat transfer on port i: in_valid[i] & in_ready[i] at a rising clk edge.
- Output load enable: ld = !out_valid | out_ready.
- State IDLE:
  - sel = first port at or after ptr+1 (mod NUM_IN) with in_valid set.
  - in_ready[sel] = ld; every other in_ready is 0.
  - If the beat transferred from sel has sop=1:
    - register the beat to the output and set out_src = sel.
    - If eop=0: go to BUSY with gnt = sel.
    - If eop=1 (single-beat packet): stay in IDLE and set ptr = sel.
  - If the beat transferred from sel has sop=0 (orphan beat):
    - drop the beat (output not loaded) and increment err_cnt.
    - set ptr = sel; stay in IDLE.
- State BUSY:
  - in_ready[gnt] = ld; every other in_ready is 0.
  - Each accepted beat is registered to the output.
  - On an accepted eop: go to IDLE and set ptr = gnt.
  - On an accepted beat with sop=1 (missing eop): forward it unchanged, increment err_cnt, stay in BUSY.
- Output register:
  - If ld and no beat transfers: out_valid <= 0.
  - If ld and a beat transfers: load valid, sop, eop, empty, data and src.
  - If ld is 0: hold all output fields.
- err_cnt saturates at 0xFFFF.
- Fairness: after a packet from port p completes, every other port with a waiting sop is served before p is served again.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid, out_sop, out_eop, out_empty, out_data, out_src and err_cnt all go to 0.
  - State = IDLE; ptr = NUM_IN-1, so port 0 has first priority.
  - in_ready is 0 while rst_n is low.
- Latency: one cycle from accepted input beat to out_valid.
- Throughput: one beat per cycle while out_ready is high.
  - No bubble between an eop from one port and the sop from the next port.
  - The transition from IDLE to BUSY takes no extra cycle.
- Backpressure: when out_ready is low and out_valid is high, every in_ready is 0 in the same cycle (combinational on out_ready). Output fields hold stable.
- in_ready depends combinationally on in_valid (IDLE only), out_ready and registered state. Inputs must not make in_valid depend on in_ready.
- Simultaneous sop on several ports in IDLE: only sel is granted; the others wait with in_ready=0.
- Wrap-around: port search wraps from NUM_IN-1 to 0.
- Reset mid-packet: the partial packet is abandoned and the next grant starts in IDLE. The downstream packer sees no eop and is reset by the same rst_n.

## Test plan
- Single port, 3-beat packet on port 2, out_ready held high:
  - out beats appear one cycle later with sop on beat 0 and eop on beat 2.
  - out_src = 2 throughout; out_empty matches the input.
- All 4 ports present a 2-beat packet at the same time:
  - output order is port 0, 1, 2, 3 with 8 contiguous valid cycles and no interleave.
  - A second round from all ports starts again at port 0.
- Port 1 streams packets continuously while port 3 raises sop:
  - port 3's packet is output directly after port 1's current eop.
  - port 1 resumes only afterwards.
- out_ready toggles 1,0,0,1,... during a 4-beat packet:
  - no beat is lost or duplicated; out_data stays stable while out_ready = 0.
  - in_ready[gnt] mirrors ld.
- Orphan beat (sop=0, valid) on port 0 in IDLE:
  - beat consumed and dropped, err_cnt = 1, no out_valid.
  - A following sop on port 0 is forwarded normally.
- rst_n pulsed low in the middle of a port 2 packet:
  - all outputs are 0 immediately; err_cnt = 0.
  - After release, port 0 (if requesting) wins first.
